// File: rtl/tconv_line_buffer.sv
// ============================================================================
// Module   : tconv_line_buffer
// Brief    : KERNEL_SIZE output line memories with per-row write/read pointers
//            and optional in-place accumulate (macro LINE_BUF_ACC_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tconv_line_buffer #(
  parameter int KERNEL_SIZE = 4,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int PTR_W       = $clog2(DEPTH)
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          wr_clr,
  input  logic                          rd_clr,
  input  logic [KERNEL_SIZE-1:0]        wr_en,
  input  logic [KERNEL_SIZE-1:0]        rd_en,
  input  logic                          acc_sel,
  input  logic [KERNEL_SIZE*DATA_W-1:0] din,
  output logic [KERNEL_SIZE*DATA_W-1:0] dout,
  output logic [KERNEL_SIZE-1:0]        dout_valid,
  output logic                          wr_wrap_err,
  output logic                          rd_wrap_err
);

  localparam logic [PTR_W-1:0] c_last_addr = PTR_W'(DEPTH - 1);

  logic [KERNEL_SIZE-1:0] w_wr_wrap;
  logic [KERNEL_SIZE-1:0] w_rd_wrap;
  logic                   r_wr_wrap_err;
  logic                   r_rd_wrap_err;

`ifndef LINE_BUF_ACC_EN
  logic w_unused_acc_sel;
  assign w_unused_acc_sel = acc_sel;
`endif

  generate
    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0]  r_wr_ptr;
      logic [PTR_W-1:0]  r_rd_ptr;
      logic [PTR_W-1:0]  w_waddr;
      logic [PTR_W-1:0]  w_raddr;
      logic [DATA_W-1:0] w_din;
      logic [DATA_W-1:0] w_wdata;
      logic [DATA_W-1:0] r_dout;
      logic              r_dout_valid;

      assign w_din   = din[r*DATA_W +: DATA_W];
      assign w_waddr = wr_clr ? '0 : r_wr_ptr;
      assign w_raddr = rd_clr ? '0 : r_rd_ptr;

`ifdef LINE_BUF_ACC_EN
      // Read-modify-write: the stored partial sum is added within the cycle.
      assign w_wdata = acc_sel ? (r_mem[w_waddr] + w_din) : w_din;
`else
      assign w_wdata = w_din;
`endif

      // Storage has no reset; contents are undefined until written.
      always_ff @(posedge clk1) begin
        if (wr_en[r]) begin
          r_mem[w_waddr] <= w_wdata;
        end
      end

      always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else begin
          if (wr_en[r]) begin
            r_wr_ptr <= w_waddr + PTR_W'(1);
          end else if (wr_clr) begin
            r_wr_ptr <= '0;
          end
          if (rd_en[r]) begin
            r_rd_ptr <= w_raddr + PTR_W'(1);
          end else if (rd_clr) begin
            r_rd_ptr <= '0;
          end
        end
      end

      // Write-first bypass so a same-address read sees the committed word.
      always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
          r_dout       <= '0;
          r_dout_valid <= 1'b0;
        end else begin
          r_dout_valid <= rd_en[r];
          if (rd_en[r]) begin
            r_dout <= (wr_en[r] && (w_waddr == w_raddr)) ? w_wdata : r_mem[w_raddr];
          end
        end
      end

      assign w_wr_wrap[r]                 = wr_en[r] && (w_waddr == c_last_addr);
      assign w_rd_wrap[r]                 = rd_en[r] && (w_raddr == c_last_addr);
      assign dout[r*DATA_W +: DATA_W]     = r_dout;
      assign dout_valid[r]                = r_dout_valid;
    end
  endgenerate

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_wrap_err <= 1'b0;
      r_rd_wrap_err <= 1'b0;
    end else begin
      if (|w_wr_wrap) begin
        r_wr_wrap_err <= 1'b1;
      end
      if (|w_rd_wrap) begin
        r_rd_wrap_err <= 1'b1;
      end
    end
  end

  assign wr_wrap_err = r_wr_wrap_err;
  assign rd_wrap_err = r_rd_wrap_err;

endmodule

`default_nettype wire

// File: tb/tb_tconv_line_buffer.sv
// ============================================================================
// Module   : tb_tconv_line_buffer
// Brief    : Directed and random checks of tconv_line_buffer against an
//            array-based line model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tconv_line_buffer;

  localparam int K     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
`ifdef LINE_BUF_ACC_EN
  localparam bit ACC_BUILT = 1'b1;
`else
  localparam bit ACC_BUILT = 1'b0;
`endif

  logic            clk1 = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_clr = 1'b0;
  logic            rd_clr = 1'b0;
  logic [K-1:0]    wr_en = '0;
  logic [K-1:0]    rd_en = '0;
  logic            acc_sel = 1'b0;
  logic [K*DW-1:0] din = '0;
  logic [K*DW-1:0] dout;
  logic [K-1:0]    dout_valid;
  logic            wr_wrap_err;
  logic            rd_wrap_err;

  int tests = 0;
  int fails = 0;

  // Reference model: plain arrays of words, pointers as integers.
  logic [DW-1:0] m_mem   [K][DEPTH];
  bit            m_known [K][DEPTH];
  int            m_wp    [K];
  int            m_rp    [K];
  logic [DW-1:0] m_dout  [K];
  bit            m_dknown[K];
  logic [K-1:0]  m_valid;
  bit            m_werr;
  bit            m_rerr;

  tconv_line_buffer #(
    .KERNEL_SIZE(K), .DATA_W(DW), .DEPTH(DEPTH)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .wr_clr(wr_clr), .rd_clr(rd_clr),
    .wr_en(wr_en), .rd_en(rd_en), .acc_sel(acc_sel), .din(din),
    .dout(dout), .dout_valid(dout_valid),
    .wr_wrap_err(wr_wrap_err), .rd_wrap_err(rd_wrap_err)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] row_out(input int r);
    return dout[r*DW +: DW];
  endfunction

  task automatic set_din(input int r, input logic [DW-1:0] v);
    din[r*DW +: DW] = v;
  endtask

  task automatic model_reset();
    for (int r = 0; r < K; r++) begin
      m_wp[r] = 0; m_rp[r] = 0; m_dout[r] = '0; m_dknown[r] = 1'b1;
      for (int a = 0; a < DEPTH; a++) m_known[r][a] = 1'b0;
    end
    m_valid = '0; m_werr = 1'b0; m_rerr = 1'b0;
  endtask

  task automatic model_step();
    for (int r = 0; r < K; r++) begin
      int wa, ra;
      wa = wr_clr ? 0 : m_wp[r];
      ra = rd_clr ? 0 : m_rp[r];
      if (wr_en[r]) begin
        if (ACC_BUILT && acc_sel) begin
          m_mem[r][wa]   = m_mem[r][wa] + din[r*DW +: DW];
          m_known[r][wa] = m_known[r][wa];
        end else begin
          m_mem[r][wa]   = din[r*DW +: DW];
          m_known[r][wa] = 1'b1;
        end
        if (wa == DEPTH - 1) m_werr = 1'b1;
        m_wp[r] = (wa + 1) % DEPTH;
      end else if (wr_clr) begin
        m_wp[r] = 0;
      end
      m_valid[r] = rd_en[r];
      if (rd_en[r]) begin
        m_dout[r]   = m_mem[r][ra];
        m_dknown[r] = m_known[r][ra];
        if (ra == DEPTH - 1) m_rerr = 1'b1;
        m_rp[r] = (ra + 1) % DEPTH;
      end else if (rd_clr) begin
        m_rp[r] = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("wr_wrap_err", 32'(wr_wrap_err), 32'(m_werr));
    chk("rd_wrap_err", 32'(rd_wrap_err), 32'(m_rerr));
    for (int r = 0; r < K; r++)
      if (m_dknown[r]) chk($sformatf("dout_row%0d", r), 32'(row_out(r)), 32'(m_dout[r]));
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
    model_step();
    check_model();
  endtask

  task automatic idle();
    wr_en = '0; rd_en = '0; wr_clr = 1'b0; rd_clr = 1'b0; acc_sel = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", 32'(dout == '0), 32'd1);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_wr_wrap_err", 32'(wr_wrap_err), 32'd0);
    chk("rst_rd_wrap_err", 32'(rd_wrap_err), 32'd0);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;

    do_reset();

    // Row 0: write 1..5, then stream back with a rewind on the first read.
    for (int i = 0; i < 5; i++) begin
      idle(); wr_en = 4'b0001; set_din(0, DW'(i + 1)); tick();
    end
    for (int i = 0; i < 5; i++) begin
      idle(); rd_en = 4'b0001; rd_clr = (i == 0); tick();
      chk("seq_row0", 32'(row_out(0)), 32'(i + 1));
      chk("seq_valid0", 32'(dout_valid[0]), 32'd1);
    end
    idle(); tick();
    chk("seq_valid_drop", 32'(dout_valid[0]), 32'd0);
    chk("seq_hold", 32'(row_out(0)), 32'd5);

    // Row 2: clear plus write lands at 0 and leaves the pointer at 1.
    idle(); wr_clr = 1'b1; wr_en = 4'b0100; set_din(2, 16'h00AA); tick();
    idle(); wr_en = 4'b0100; set_din(2, 16'h00BB); tick();
    idle(); wr_en = 4'b0100; set_din(2, 16'h00CC); tick();
    idle(); rd_clr = 1'b1; rd_en = 4'b0100; tick();
    chk("clr_row2_a0", 32'(row_out(2)), 32'h00AA);
    idle(); rd_en = 4'b0100; tick();
    chk("clr_row2_a1", 32'(row_out(2)), 32'h00BB);
    idle(); rd_en = 4'b0100; tick();
    chk("clr_row2_a2", 32'(row_out(2)), 32'h00CC);

    // Row 1: same-address write and read in one cycle.
    idle(); wr_clr = 1'b1; rd_clr = 1'b1; wr_en = 4'b0010; rd_en = 4'b0010;
    set_din(1, 16'h1234); tick();
    chk("bypass_row1", 32'(row_out(1)), 32'h1234);

    // Row 3: DEPTH+1 writes wrap the pointer and overwrite address 0.
    for (int i = 0; i <= DEPTH; i++) begin
      idle(); wr_clr = (i == 0); wr_en = 4'b1000; set_din(3, DW'(16'h0300 + i)); tick();
      if (i == DEPTH - 2) chk("wrap_before", 32'(wr_wrap_err), 32'd0);
      if (i == DEPTH - 1) chk("wrap_set", 32'(wr_wrap_err), 32'd1);
    end
    idle(); rd_clr = 1'b1; rd_en = 4'b1000; tick();
    chk("wrap_overwrite", 32'(row_out(3)), 32'h0300 + DEPTH);
    idle(); tick(); tick();
    chk("wrap_sticky", 32'(wr_wrap_err), 32'd1);
    do_reset();

    // Accumulate: 0x10 + 0x05, then 0xFFFF + 0x0002.
    exp_a = ACC_BUILT ? 16'h0015 : 16'h0005;
    exp_b = ACC_BUILT ? 16'h0001 : 16'h0002;
    idle(); wr_clr = 1'b1; wr_en = 4'b0001; set_din(0, 16'h0010); tick();
    idle(); wr_clr = 1'b1; wr_en = 4'b0001; acc_sel = 1'b1; set_din(0, 16'h0005); tick();
    idle(); rd_clr = 1'b1; rd_en = 4'b0001; tick();
    chk("acc_sum", 32'(row_out(0)), 32'(exp_a));
    idle(); wr_clr = 1'b1; wr_en = 4'b0001; set_din(0, 16'hFFFF); tick();
    idle(); wr_clr = 1'b1; wr_en = 4'b0001; acc_sel = 1'b1; set_din(0, 16'h0002); tick();
    idle(); rd_clr = 1'b1; rd_en = 4'b0001; tick();
    chk("acc_wrap", 32'(row_out(0)), 32'(exp_b));

    // Random mix of strobes, clears and accumulate, with a mid-line reset.
    for (int i = 0; i < 400; i++) begin
      wr_en   = K'($urandom);
      rd_en   = K'($urandom);
      wr_clr  = ($urandom_range(0, 15) == 0);
      rd_clr  = ($urandom_range(0, 15) == 0);
      acc_sel = 1'($urandom);
      din     = {$urandom, $urandom};
      tick();
      if (i == 200) do_reset();
    end

    idle(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
